// File: rtl/t03_countdown_timer.sv
// Prescaled countdown timer with IDLE/RUNNING/PAUSED/EXPIRED states and one-cycle expiry pulse.
// Define T03_TIMER_AUTORELOAD_EN to reload from the last loaded value on expiry instead of stopping.
module t03_countdown_timer #(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 10
) (
    input  logic             hwclk,
    input  logic             rst,
    input  logic             tick_i,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             start,
    input  logic             pause,
    input  logic             clear,
    output logic [WIDTH-1:0] count,
    output logic             running,
    output logic             expired,
    output logic             done_pulse,
    output logic [1:0]       dbg_state_o,
    output logic [7:0]       dbg_psc_o
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUNNING = 2'd1;
    localparam logic [1:0] ST_PAUSED  = 2'd2;
    localparam logic [1:0] ST_EXPIRED = 2'd3;

    localparam logic [7:0] PSC_MAX = 8'(PRESCALE - 1);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] count_q,   count_d;
    logic [WIDTH-1:0] reload_q,  reload_d;
    logic [7:0]       psc_q,     psc_d;
    logic             done_q,    done_d;
    logic             running_q, running_d;
    logic             expired_q, expired_d;

    // Controls are single-cycle strobes with no handshake; when several are high in
    // one cycle only the highest priority acts: clear > load > start > pause > tick_i.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        psc_d    = psc_q;
        done_d   = 1'b0;
        if (clear) begin
            count_d = '0;
            psc_d   = '0;
            state_d = ST_IDLE;
        end else if (load) begin
            count_d  = load_val;
            reload_d = load_val;
            psc_d    = '0;
            state_d  = ST_IDLE;
        end else if (start) begin
            if ((state_q == ST_IDLE || state_q == ST_PAUSED) && count_q != '0) begin
                state_d = ST_RUNNING;
            end
        end else if (pause) begin
            if (state_q == ST_RUNNING) begin
                state_d = ST_PAUSED;
            end
        end else if (tick_i && state_q == ST_RUNNING) begin
            if (psc_q != PSC_MAX) begin
                psc_d = psc_q + 8'd1;
            end else begin
                psc_d = '0;
                if (count_q == WIDTH'(1)) begin
                    done_d = 1'b1;
`ifdef T03_TIMER_AUTORELOAD_EN
                    count_d = reload_q;
                    if (reload_q == '0) begin
                        state_d = ST_IDLE;
                    end
`else
                    count_d = '0;
                    state_d = ST_EXPIRED;
`endif
                end else if (count_q != '0) begin
                    count_d = count_q - WIDTH'(1);
                end
            end
        end
        running_d = (state_d == ST_RUNNING);
        expired_d = (state_d == ST_EXPIRED);
    end

    always_ff @(posedge hwclk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            count_q   <= '0;
            reload_q  <= '0;
            psc_q     <= '0;
            done_q    <= 1'b0;
            running_q <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            reload_q  <= reload_d;
            psc_q     <= psc_d;
            done_q    <= done_d;
            running_q <= running_d;
            expired_q <= expired_d;
        end
    end

    assign count       = count_q;
    assign running     = running_q;
    assign expired     = expired_q;
    assign done_pulse  = done_q;
    assign dbg_state_o = state_q;
    assign dbg_psc_o   = psc_q;

endmodule

// File: tb/tb_t03_countdown_timer.sv
// Directed bench for t03_countdown_timer at WIDTH=8, PRESCALE=2.
module tb_t03_countdown_timer;

    localparam int ST_IDLE    = 0;
    localparam int ST_RUNNING = 1;
    localparam int ST_PAUSED  = 2;
    localparam int ST_EXPIRED = 3;

    logic       hwclk = 1'b0;
    logic       rst = 1'b0;
    logic       tick_i = 1'b0;
    logic       load = 1'b0;
    logic [7:0] load_val = '0;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       clear = 1'b0;
    logic [7:0] count;
    logic       running;
    logic       expired;
    logic       done_pulse;
    logic [1:0] dbg_state_o;
    logic [7:0] dbg_psc_o;

    int total = 0;
    int bad   = 0;

    t03_countdown_timer #(.WIDTH(8), .PRESCALE(2)) dut (
        .hwclk       (hwclk),
        .rst         (rst),
        .tick_i      (tick_i),
        .load        (load),
        .load_val    (load_val),
        .start       (start),
        .pause       (pause),
        .clear       (clear),
        .count       (count),
        .running     (running),
        .expired     (expired),
        .done_pulse  (done_pulse),
        .dbg_state_o (dbg_state_o),
        .dbg_psc_o   (dbg_psc_o)
    );

    // clock / reset
    always #5 hwclk = ~hwclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // drivers: inputs change 1 time unit after the edge and outputs are sampled there too
    task automatic cyc();
        @(posedge hwclk);
        #1;
    endtask

    task automatic do_rst();
        rst = 1'b1; cyc(); rst = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load = 1'b1; load_val = v; cyc(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; cyc(); start = 1'b0;
    endtask

    task automatic do_pause();
        pause = 1'b1; cyc(); pause = 1'b0;
    endtask

    task automatic do_tick();
        tick_i = 1'b1; cyc(); tick_i = 1'b0;
    endtask

    task automatic check_state(input string tag, input int cnt, input int st);
        check({tag, ".count"}, 32'(count), 32'(cnt));
        check({tag, ".state"}, 32'(dbg_state_o), 32'(st));
        check({tag, ".running"}, 32'(running), 32'(st == ST_RUNNING));
        check({tag, ".expired"}, 32'(expired), 32'(st == ST_EXPIRED));
    endtask

    initial begin
        int exp_cnt [6];
        cyc();
        do_rst();
        check_state("reset", 0, ST_IDLE);
        check("reset.done", 32'(done_pulse), 0);
        check("reset.psc", 32'(dbg_psc_o), 0);

        // pause and start are no-ops in IDLE with count 0
        do_pause();
        check_state("idle_pause", 0, ST_IDLE);

`ifndef T03_TIMER_AUTORELOAD_EN
        // basic countdown to expiry
        exp_cnt = '{3, 2, 2, 1, 1, 0};
        do_load(8'd3);
        check_state("load3", 3, ST_IDLE);
        do_start();
        check_state("start3", 3, ST_RUNNING);
        for (int i = 0; i < 6; i++) begin
            do_tick();
            check($sformatf("cd.tick%0d.count", i + 1), 32'(count), 32'(exp_cnt[i]));
            check($sformatf("cd.tick%0d.done", i + 1), 32'(done_pulse), 32'(i == 5));
        end
        check_state("expired", 0, ST_EXPIRED);
        cyc();
        check("expired.done_drop", 32'(done_pulse), 0);
        check_state("expired_hold", 0, ST_EXPIRED);
        do_tick();
        do_start();
        check_state("expired_ignore", 0, ST_EXPIRED);
        check("expired_ignore.done", 32'(done_pulse), 0);
        clear = 1'b1; cyc(); clear = 1'b0;
        check_state("expired_clear", 0, ST_IDLE);
`endif

        // pause / resume
        do_load(8'd5);
        do_start();
        do_tick(); do_tick(); do_tick();
        check_state("pr.run", 4, ST_RUNNING);
        check("pr.run.psc", 32'(dbg_psc_o), 1);
        do_pause();
        check_state("pr.paused", 4, ST_PAUSED);
        for (int i = 0; i < 4; i++) do_tick();
        check_state("pr.paused_ticks", 4, ST_PAUSED);
        check("pr.paused.psc", 32'(dbg_psc_o), 1);
        do_start();
        check_state("pr.resume", 4, ST_RUNNING);
        do_tick();
        check_state("pr.resume_tick", 3, ST_RUNNING);
        check("pr.resume.psc", 32'(dbg_psc_o), 0);

        // start and pause together while running keep it running
        start = 1'b1; pause = 1'b1; cyc(); start = 1'b0; pause = 1'b0;
        check_state("start_pause", 3, ST_RUNNING);

        // load while running returns to IDLE
        do_load(8'd0);
        check_state("load0", 0, ST_IDLE);
        do_start();
        check_state("load0.start", 0, ST_IDLE);
        check("load0.done", 32'(done_pulse), 0);

        // tick and pause in the same cycle with psc=1, count=2
        do_load(8'd3);
        do_start();
        do_tick(); do_tick(); do_tick();
        check("tp.pre.psc", 32'(dbg_psc_o), 1);
        check("tp.pre.count", 32'(count), 2);
        tick_i = 1'b1; pause = 1'b1; cyc(); tick_i = 1'b0; pause = 1'b0;
        check_state("tick_pause", 2, ST_PAUSED);
        check("tick_pause.psc", 32'(dbg_psc_o), 1);

        // clear beats load
        clear = 1'b1; load = 1'b1; load_val = 8'd9; cyc(); clear = 1'b0; load = 1'b0;
        check_state("clear_load", 0, ST_IDLE);

        // reset mid-count
        do_load(8'd4);
        do_start();
        do_tick(); do_tick(); do_tick();
        check_state("rst.pre", 3, ST_RUNNING);
        do_rst();
        check_state("rst.mid", 0, ST_IDLE);
        check("rst.mid.psc", 32'(dbg_psc_o), 0);
        check("rst.mid.done", 32'(done_pulse), 0);
        do_start();
        check_state("rst.start", 0, ST_IDLE);
        check("rst.start.done", 32'(done_pulse), 0);

        // reset dominates a simultaneous load
        rst = 1'b1; load = 1'b1; load_val = 8'd7; cyc(); rst = 1'b0; load = 1'b0;
        check_state("rst_load", 0, ST_IDLE);

`ifdef T03_TIMER_AUTORELOAD_EN
        // auto-reload: two expiries, count returns to 2
        exp_cnt = '{2, 1, 1, 2, 0, 0};
        do_load(8'd2);
        do_start();
        for (int i = 0; i < 8; i++) begin
            do_tick();
            check($sformatf("ar.tick%0d.count", i + 1), 32'(count), 32'(exp_cnt[i % 4]));
            check($sformatf("ar.tick%0d.done", i + 1), 32'(done_pulse), 32'(i == 3 || i == 7));
            check($sformatf("ar.tick%0d.running", i + 1), 32'(running), 1);
            check($sformatf("ar.tick%0d.expired", i + 1), 32'(expired), 0);
        end
        cyc();
        check("ar.done_drop", 32'(done_pulse), 0);
`endif

        // report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
